// File: rtl/shift_normalizer.sv
// shift_normalizer: iterative one-bit-per-clock normalizer.
// Left mode shifts the operand up until its MSB is set; right mode shifts it
// down until its LSB is set. The result word and the number of single-bit
// shifts applied are reported with a one-cycle done pulse. An all-zero operand
// cannot be normalized and is flagged with zero=1.
module shift_normalizer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] i,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o,
    output logic [CNT_W-1:0] shift,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q,  work_d;
    logic             mode_q,  mode_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] o_q,     o_d;
    logic [CNT_W-1:0] shift_q, shift_d;
    logic             zero_q,  zero_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // The bit the current mode is hunting for.
    logic target_hit;
    assign target_hit = mode_q ? work_q[0] : work_q[WIDTH-1];

    // Next-state and output computation for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        // NOTE: every _d starts from its held value so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d = state_q;
        work_d  = work_q;
        mode_d  = mode_q;
        count_d = count_q;
        o_d     = o_q;
        shift_d = shift_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    work_d  = i;
                    mode_d  = mode;
                    count_d = '0;
                    zero_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // busy rises on the first RUN edge, one edge after acceptance.
                busy_d = 1'b1;
                if (work_q == '0) begin
                    zero_d  = 1'b1;
                    o_d     = '0;
                    shift_d = '0;
                    state_d = DONE;
                end else if (target_hit) begin
                    o_d     = work_q;
                    shift_d = count_q;
                    state_d = DONE;
                end else begin
                    // A nonzero word reaches its target within WIDTH-1
                    // shifts, so count cannot wrap.
                    work_d  = mode_q ? {1'b0, work_q[WIDTH-1:1]}
                                     : {work_q[WIDTH-2:0], 1'b0};
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE: begin
                // start is not looked at here; it is neither queued nor restarted.
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            mode_q  <= 1'b0;
            count_q <= '0;
            o_q     <= '0;
            shift_q <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            o_q     <= o_d;
            shift_q <= shift_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign o     = o_q;
    assign shift = shift_q;
    assign zero  = zero_q;

endmodule
